// File: rtl/tty_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tty_out_fifo
// Description : CPU-to-display character FIFO with a one-char-per-frame drain FSM.
//               Optional dropped-push counter enabled by TTY_FIFO_OVF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tty_out_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  sys_clock,
  input  logic                  reset,
  input  logic                  cpu_clken,
  input  logic                  clr_screen,
  input  logic                  address,
  input  logic                  w_en,
  input  logic [WIDTH-1:0]      din,
  output logic                  busy,
  input  logic                  disp_ready,
  output logic                  disp_w_en,
  output logic [WIDTH-1:0]      disp_din,
  output logic [DEPTH_LOG2:0]   level
`ifdef TTY_FIFO_OVF_CNT_EN
  ,
  output logic [7:0]            ovf_count
`endif
);

  localparam int                       DEPTH      = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]      c_LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]      c_LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0]    c_PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_REL  = 2'd2
  } state_t;

  state_t                  r_state, w_state_next;
  logic [WIDTH-1:0]        r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]     r_level, w_level_next;
  logic                    r_busy, r_cpu_seen;
  logic [WIDTH-1:0]        r_disp_din;
  logic                    w_push_req, w_full, w_push_ok, w_pop, w_load;

  // One push per CPU strobe; a full FIFO still accepts if a pop frees a slot.
  assign w_push_req = cpu_clken & w_en & ~address & ~r_cpu_seen;
  assign w_full     = (r_level == c_LVL_FULL);
  assign w_push_ok  = w_push_req & (~w_full | w_pop) & ~clr_screen;

  always_comb begin
    w_level_next = r_level;
    case ({w_push_ok, w_pop})
      2'b10:   w_level_next = r_level + c_LVL_ONE;
      2'b01:   w_level_next = r_level - c_LVL_ONE;
      default: w_level_next = r_level;
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (reset)
      r_cpu_seen <= 1'b0;
    else if (w_push_req)
      r_cpu_seen <= 1'b1;
    else if (~cpu_clken & ~w_en)
      r_cpu_seen <= 1'b0;
  end

  always_ff @(posedge sys_clock) begin
    if (reset || clr_screen) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_busy   <= 1'b0;
    end else begin
      if (w_push_ok)
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      r_level <= w_level_next;
      r_busy  <= (w_level_next == c_LVL_FULL);
    end
  end

  always_ff @(posedge sys_clock) begin
    if (w_push_ok)
      r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge sys_clock) begin
    if (reset)
      r_disp_din <= '0;
    else if (w_load)
      r_disp_din <= r_mem[r_rd_ptr];
  end

  always_ff @(posedge sys_clock) begin
    if (reset || clr_screen)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  // REL waits for a CPU-idle cycle so the display can re-arm before the next char.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_level != '0) && disp_ready) begin
          w_load       = 1'b1;
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!disp_ready) begin
          w_pop        = 1'b1;
          w_state_next = S_REL;
        end
      end
      S_REL: begin
        if (!cpu_clken)
          w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign busy      = r_busy;
  assign level     = r_level;
  assign disp_din  = r_disp_din;
  assign disp_w_en = (r_state == S_HOLD);

`ifdef TTY_FIFO_OVF_CNT_EN
  logic [7:0] r_ovf_count;

  always_ff @(posedge sys_clock) begin
    if (reset || clr_screen)
      r_ovf_count <= 8'd0;
    else if (w_push_req && w_full && !w_pop && (r_ovf_count != 8'hFF))
      r_ovf_count <= r_ovf_count + 8'd1;
  end

  assign ovf_count = r_ovf_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tty_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_tty_out_fifo
// Description : Scoreboard bench for tty_out_fifo; queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tty_out_fifo;

  localparam int DEPTH = 16;

  logic       sys_clock = 1'b0;
  logic       reset, cpu_clken, clr_screen, address, w_en, disp_ready;
  logic [7:0] din;
  wire        busy, disp_w_en;
  wire  [7:0] disp_din;
  wire  [4:0] level;
`ifdef TTY_FIFO_OVF_CNT_EN
  wire  [7:0] ovf_count;
`endif

  tty_out_fifo #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
    .sys_clock  (sys_clock),
    .reset      (reset),
    .cpu_clken  (cpu_clken),
    .clr_screen (clr_screen),
    .address    (address),
    .w_en       (w_en),
    .din        (din),
    .busy       (busy),
    .disp_ready (disp_ready),
    .disp_w_en  (disp_w_en),
    .disp_din   (disp_din),
    .level      (level)
`ifdef TTY_FIFO_OVF_CNT_EN
    ,
    .ovf_count  (ovf_count)
`endif
  );

  always #5 sys_clock = ~sys_clock;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] q_exp[$];
  bit         m_seen  = 1'b0;
  bit         mon_en  = 1'b0;
  bit         prev_wen = 1'b0;
  logic [7:0] held = 8'h00;
  int         m_ovf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue; expected chars are its front entries.
  always @(negedge sys_clock) begin
    if (mon_en) begin
      bit push_req, pop;
      chk("level", 32'(level), 32'(q_exp.size()));
      chk("busy", 32'(busy), 32'(q_exp.size() == DEPTH));
`ifdef TTY_FIFO_OVF_CNT_EN
      chk("ovf_count", 32'(ovf_count), 32'(m_ovf));
`endif
      if (disp_w_en && !prev_wen) begin
        if (q_exp.size() == 0)
          chk("rise_with_empty_model", 32'd1, 32'd0);
        else
          chk("disp_din", 32'(disp_din), 32'(q_exp[0]));
      end
      if (disp_w_en && prev_wen)
        chk("din_stable", 32'(disp_din), 32'(held));

      push_req = cpu_clken && w_en && !address && !m_seen;
      if (reset) begin
        q_exp.delete();
        m_seen = 1'b0;
        m_ovf  = 0;
      end else begin
        if (push_req)
          m_seen = 1'b1;
        else if (!cpu_clken && !w_en)
          m_seen = 1'b0;
        if (clr_screen) begin
          q_exp.delete();
          m_ovf = 0;
        end else begin
          pop = disp_w_en && !disp_ready;
          if (pop)
            void'(q_exp.pop_front());
          if (push_req) begin
            if (q_exp.size() < DEPTH)
              q_exp.push_back(din);
            else if (m_ovf < 255)
              m_ovf++;
          end
        end
      end
      prev_wen = disp_w_en;
      held     = disp_din;
    end
  end

  task automatic tick();
    @(posedge sys_clock);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    cpu_clken = 1'b1; w_en = 1'b1; address = 1'b0; din = d;
    tick();
    cpu_clken = 1'b0; w_en = 1'b0;
    tick();
  endtask

  task automatic wait_wen(input logic v, input string name);
    int k = 0;
    while (disp_w_en !== v && k < 20) begin
      tick();
      k++;
    end
    chk(name, 32'(disp_w_en), 32'(v));
  endtask

  task automatic drain_one(output logic [7:0] d);
    cpu_clken  = 1'b0;
    w_en       = 1'b0;
    disp_ready = 1'b1;
    wait_wen(1'b1, "drain_rise_timeout");
    d = disp_din;
    disp_ready = 1'b0;
    tick();
    chk("drain_fall", 32'(disp_w_en), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] last;
    int         k;

    reset = 1'b1; cpu_clken = 1'b0; clr_screen = 1'b0; address = 1'b0;
    w_en = 1'b0; din = 8'h00; disp_ready = 1'b1;
    repeat (3) @(posedge sys_clock);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_disp_w_en", 32'(disp_w_en), 32'd0);
    chk("rst_disp_din", 32'(disp_din), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Empty FIFO to display in two cycles, then consume.
    cpu_clken = 1'b1; w_en = 1'b1; din = 8'hC1;
    tick();
    cpu_clken = 1'b0; w_en = 1'b0;
    tick();
    chk("t1_latency_wen", 32'(disp_w_en), 32'd1);
    chk("t1_latency_din", 32'(disp_din), 32'hC1);
    disp_ready = 1'b0;
    tick();
    chk("t1_wen_drop", 32'(disp_w_en), 32'd0);
    chk("t1_level", 32'(level), 32'd0);

    // Fill to full, then one dropped push.
    for (int i = 0; i < 16; i++)
      push(8'(i));
    chk("t2_level_full", 32'(level), 32'd16);
    chk("t2_busy", 32'(busy), 32'd1);
    push(8'hAA);
    chk("t2_level_after_drop", 32'(level), 32'd16);
`ifdef TTY_FIFO_OVF_CNT_EN
    chk("t2_ovf_count", 32'(ovf_count), 32'd1);
`endif

    // One char per frame, in order.
    for (int i = 0; i < 16; i++) begin
      drain_one(d);
      chk("t3_order", 32'(d), 32'(i));
      if (i == 0)
        chk("t3_busy_after_pop", 32'(busy), 32'd0);
    end
    chk("t3_level_empty", 32'(level), 32'd0);

    // A held strobe pushes once; address=1 never pushes.
    w_en = 1'b1; address = 1'b0; din = 8'h44;
    repeat (3) begin
      cpu_clken = 1'b1; tick();
      cpu_clken = 1'b0; tick();
    end
    w_en = 1'b0; tick();
    chk("t4_one_push", 32'(level), 32'd1);
    w_en = 1'b1; address = 1'b1; din = 8'h45;
    repeat (3) begin
      cpu_clken = 1'b1; tick();
      cpu_clken = 1'b0; tick();
    end
    w_en = 1'b0; address = 1'b0; tick();
    chk("t4_addr1_no_push", 32'(level), 32'd1);
    clr_screen = 1'b1; tick();
    clr_screen = 1'b0;
    chk("t4_clr_level", 32'(level), 32'd0);

    // Flush while holding a char, with a colliding push.
    for (int i = 0; i < 5; i++)
      push(8'h50 + 8'(i));
    disp_ready = 1'b1;
    wait_wen(1'b1, "t5_hold_timeout");
    chk("t5_level_hold", 32'(level), 32'd5);
    cpu_clken = 1'b1; w_en = 1'b1; din = 8'h55; clr_screen = 1'b1;
    tick();
    cpu_clken = 1'b0; w_en = 1'b0; clr_screen = 1'b0;
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_wen", 32'(disp_w_en), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    tick();

    // Push into a full FIFO on the same cycle as a pop.
    push(8'h60);
    chk("t6_hold", 32'(disp_w_en), 32'd1);
    for (int i = 1; i < 16; i++)
      push(8'h60 + 8'(i));
    chk("t6_full", 32'(level), 32'd16);
    cpu_clken = 1'b1; w_en = 1'b1; din = 8'hBB; disp_ready = 1'b0;
    tick();
    cpu_clken = 1'b0; w_en = 1'b0;
    chk("t6_level_kept", 32'(level), 32'd16);
    chk("t6_busy_kept", 32'(busy), 32'd1);
    last = 8'h00;
    k = 0;
    while (level != 0 && k < 20) begin
      drain_one(last);
      k++;
    end
    chk("t6_last_char", 32'(last), 32'hBB);

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 3000; c++) begin
      cpu_clken  = 1'($urandom_range(0, 1));
      w_en       = ($urandom_range(0, 2) != 0);
      address    = ($urandom_range(0, 7) == 0);
      din        = 8'($urandom);
      disp_ready = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr_screen = ($urandom_range(0, 99) == 0);
      tick();
    end
    clr_screen = 1'b0; address = 1'b0;
    k = 0;
    while (level != 0 && k < 40) begin
      drain_one(d);
      k++;
    end
    chk("final_level", 32'(level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
